// File: rtl/instruction_execute_pkg.sv
// Shared encodings for the decode/execute pair of the 3-bit computer.
// Decode drives these codes and execute interprets them.
package instruction_execute_pkg;

  typedef enum logic [2:0] {
    ADV = 3'd0,
    BXL = 3'd1,
    BST = 3'd2,
    JNZ = 3'd3,
    BXC = 3'd4,
    OUT = 3'd5,
    BDV = 3'd6,
    CDV = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    REG_B_SEL    = 2'd0,
    COMBO_OP_SEL = 2'd1
  } op1_sel_e;

  typedef enum logic [1:0] {
    LIT_OP_SEL = 2'd0,
    REG_C_SEL  = 2'd1
  } op2_sel_e;

  typedef enum logic [1:0] {
    SHIFT_SEL = 2'd0,
    XOR_SEL   = 2'd1,
    MOD_SEL   = 2'd2,
    JUMP_SEL  = 2'd3
  } operation_e;

  localparam logic [4:0] NO_WR_EN    = 5'd0;
  localparam logic [4:0] REG_A_WR_EN = 5'd1;
  localparam logic [4:0] REG_B_WR_EN = 5'd2;
  localparam logic [4:0] REG_C_WR_EN = 5'd4;
  localparam logic [4:0] REG_O_WR_EN = 5'd8;

  // The combo operand only matters as the shift amount or as a selected operand 1.
  function automatic logic combo_used(input logic [1:0] op1_sel,
                                      input logic [1:0] operation_sel);
    return (operation_sel == SHIFT_SEL) ||
           ((operation_sel != JUMP_SEL) && (op1_sel == COMBO_OP_SEL));
  endfunction

endpackage

// File: rtl/instruction_execute_alu.sv
// Combinational execute datapath: combo select, operand muxes,
// bounded right shift, xor and mod-8.
module exec_alu
  import instruction_execute_pkg::*;
#(
  parameter int unsigned REG_W = 48
) (
  input  logic [REG_W-1:0] reg_a,
  input  logic [REG_W-1:0] reg_b,
  input  logic [REG_W-1:0] reg_c,
  input  logic [2:0]       operand,
  input  logic [1:0]       op1_sel,
  input  logic [1:0]       op2_sel,
  input  logic [1:0]       operation_sel,
  output logic [REG_W-1:0] result,
  output logic             combo7
);

  localparam logic [REG_W-1:0] SHIFT_LIMIT = REG_W'(REG_W);

  logic [REG_W-1:0] literal;
  logic [REG_W-1:0] combo;
  logic [REG_W-1:0] op1;
  logic [REG_W-1:0] op2;
  logic [REG_W-1:0] shifted;

  assign literal = {{(REG_W-3){1'b0}}, operand};
  assign combo7  = (operand == 3'd7) && combo_used(op1_sel, operation_sel);

  always_comb begin
    combo = '0;
    case (operand)
      3'd4:    combo = reg_a;
      3'd5:    combo = reg_b;
      3'd6:    combo = reg_c;
      3'd7:    combo = '0;
      default: combo = literal;
    endcase
  end

  always_comb begin
    op1 = '0;
    case (op1_sel)
      REG_B_SEL:    op1 = reg_b;
      COMBO_OP_SEL: op1 = combo;
      default:      op1 = '0;
    endcase
  end

  always_comb begin
    op2 = '0;
    case (op2_sel)
      LIT_OP_SEL: op2 = literal;
      REG_C_SEL:  op2 = reg_c;
      default:    op2 = '0;
    endcase
  end

  // Shift amounts at or beyond the register width flush to zero explicitly.
  always_comb begin
    shifted = '0;
    if (combo < SHIFT_LIMIT) shifted = reg_a >> combo;
  end

  always_comb begin
    result = '0;
    case (operation_sel)
      SHIFT_SEL: result = shifted;
      XOR_SEL:   result = op1 ^ op2;
      MOD_SEL:   result = {{(REG_W-3){1'b0}}, op1[2:0]};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/instruction_execute.sv
// Execute/writeback stage: architectural registers A/B/C, output word
// handshake, jump request and post-jump shadow discard.
module instruction_execute
  import instruction_execute_pkg::*;
#(
  parameter int unsigned REG_W       = 48,
  parameter int unsigned JUMP_SHADOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [2:0]       operand_id_reg,
  input  logic [1:0]       op1_sel,
  input  logic [1:0]       op2_sel,
  input  logic [1:0]       operation_sel,
  input  logic [4:0]       reg_wr_en,
  input  logic             load_en,
  input  logic [REG_W-1:0] load_a,
  input  logic [REG_W-1:0] load_b,
  input  logic [REG_W-1:0] load_c,
  output logic             halt_id,
  output logic             out_valid,
  output logic [2:0]       out_data,
  input  logic             out_ready,
  output logic             jump_req,
  output logic [2:0]       jump_addr,
  output logic             err_combo7,
  output logic [REG_W-1:0] reg_a,
  output logic [REG_W-1:0] reg_b,
  output logic [REG_W-1:0] reg_c
);

  localparam int unsigned SH_W = (JUMP_SHADOW < 1) ? 1 : $clog2(JUMP_SHADOW + 1);

  logic [SH_W-1:0]  shadow;
  logic [REG_W-1:0] result;
  logic             combo7;
  logic             fire;
  logic             exec_en;
  logic             is_jump;
  logic             write_o;
  logic             wr_en_unused;

  assign wr_en_unused = reg_wr_en[4];

  exec_alu #(
    .REG_W(REG_W)
  ) u_alu (
    .reg_a         (reg_a),
    .reg_b         (reg_b),
    .reg_c         (reg_c),
    .operand       (operand_id_reg),
    .op1_sel       (op1_sel),
    .op2_sel       (op2_sel),
    .operation_sel (operation_sel),
    .result        (result),
    .combo7        (combo7)
  );

  assign halt_id = load_en | (out_valid & ~out_ready);
  assign fire    = id_valid & ~halt_id;
  assign exec_en = fire & (shadow == '0);
  assign is_jump = (operation_sel == JUMP_SEL);
  assign write_o = exec_en & ~is_jump & reg_wr_en[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a      <= '0;
      reg_b      <= '0;
      reg_c      <= '0;
      shadow     <= '0;
      jump_req   <= 1'b0;
      jump_addr  <= '0;
      err_combo7 <= 1'b0;
    end else begin
      jump_req <= 1'b0;
      if (load_en) begin
        reg_a  <= load_a;
        reg_b  <= load_b;
        reg_c  <= load_c;
        shadow <= '0;
      end else if (fire) begin
        if (shadow != '0) begin
          shadow <= shadow - SH_W'(1);
        end else if (is_jump) begin
          if (reg_a != '0) begin
            jump_req  <= 1'b1;
            jump_addr <= operand_id_reg;
            shadow    <= SH_W'(JUMP_SHADOW);
          end
        end else begin
          if (reg_wr_en[0]) reg_a <= result;
          if (reg_wr_en[1]) reg_b <= result;
          if (reg_wr_en[2]) reg_c <= result;
        end
        if (exec_en && combo7) err_combo7 <= 1'b1;
      end
    end
  end

  // A new word may overwrite the one being accepted on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (write_o) begin
      out_valid <= 1'b1;
      out_data  <= result[2:0];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_execute.sv
// Directed plus randomized bench for instruction_execute against a
// cycle-level behavioural model of the execute stage.
module tb_instruction_execute;
  import instruction_execute_pkg::*;

  localparam int unsigned W  = 48;
  localparam int unsigned SH = 1;

  logic         clk;
  logic         rst_n;
  logic         id_valid;
  logic [2:0]   operand_id_reg;
  logic [1:0]   op1_sel;
  logic [1:0]   op2_sel;
  logic [1:0]   operation_sel;
  logic [4:0]   reg_wr_en;
  logic         load_en;
  logic [W-1:0] load_a;
  logic [W-1:0] load_b;
  logic [W-1:0] load_c;
  logic         halt_id;
  logic         out_valid;
  logic [2:0]   out_data;
  logic         out_ready;
  logic         jump_req;
  logic [2:0]   jump_addr;
  logic         err_combo7;
  logic [W-1:0] reg_a;
  logic [W-1:0] reg_b;
  logic [W-1:0] reg_c;

  instruction_execute #(
    .REG_W       (W),
    .JUMP_SHADOW (SH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .operand_id_reg (operand_id_reg),
    .op1_sel        (op1_sel),
    .op2_sel        (op2_sel),
    .operation_sel  (operation_sel),
    .reg_wr_en      (reg_wr_en),
    .load_en        (load_en),
    .load_a         (load_a),
    .load_b         (load_b),
    .load_c         (load_c),
    .halt_id        (halt_id),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .jump_req       (jump_req),
    .jump_addr      (jump_addr),
    .err_combo7     (err_combo7),
    .reg_a          (reg_a),
    .reg_b          (reg_b),
    .reg_c          (reg_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic [W-1:0] m_a, m_b, m_c;
  bit           m_ov;
  logic [2:0]   m_od;
  bit           m_jr;
  logic [2:0]   m_ja;
  bit           m_err;
  int           m_shadow;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_c = '0;
    m_ov = 0; m_od = '0; m_jr = 0; m_ja = '0; m_err = 0; m_shadow = 0;
  endtask

  task automatic check_all(input string when);
    chk({when, "_reg_a"},      64'(reg_a),      64'(m_a));
    chk({when, "_reg_b"},      64'(reg_b),      64'(m_b));
    chk({when, "_reg_c"},      64'(reg_c),      64'(m_c));
    chk({when, "_out_valid"},  64'(out_valid),  64'(m_ov));
    chk({when, "_out_data"},   64'(out_data),   64'(m_od));
    chk({when, "_jump_req"},   64'(jump_req),   64'(m_jr));
    chk({when, "_jump_addr"},  64'(jump_addr),  64'(m_ja));
    chk({when, "_err_combo7"}, 64'(err_combo7), 64'(m_err));
  endtask

  function automatic logic [W-1:0] m_combo(input logic [2:0] opd);
    case (opd)
      3'd4:    return m_a;
      3'd5:    return m_b;
      3'd6:    return m_c;
      3'd7:    return '0;
      default: return W'(opd);
    endcase
  endfunction

  // Drive one cycle of inputs, predict the next state from the rules, check after the edge.
  task automatic cycle(input bit v, input logic [2:0] opd, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] op, input logic [4:0] we,
                       input bit ld, input logic [W-1:0] la, input logic [W-1:0] lb,
                       input logic [W-1:0] lc, input bit rdy);
    logic [W-1:0] na, nb, nc, cv, x1, x2, res;
    logic [2:0]   nod, nja;
    bit           nov, njr, nerr, halt, wrote_o;
    int           nsh;
    id_valid = v; operand_id_reg = opd; op1_sel = s1; op2_sel = s2;
    operation_sel = op; reg_wr_en = we; load_en = ld;
    load_a = la; load_b = lb; load_c = lc; out_ready = rdy;
    #1;
    halt = ld || (m_ov && !rdy);
    chk("halt_id", 64'(halt_id), 64'(halt));
    na = m_a; nb = m_b; nc = m_c; nov = m_ov; nod = m_od;
    njr = 0; nja = m_ja; nerr = m_err; nsh = m_shadow; wrote_o = 0; res = '0;
    if (ld) begin
      na = la; nb = lb; nc = lc; nsh = 0;
    end else if (v && !halt) begin
      if (m_shadow > 0) begin
        nsh = m_shadow - 1;
      end else if (op == 2'd3) begin
        if (m_a != 0) begin
          njr = 1; nja = opd; nsh = SH;
        end
      end else begin
        cv = m_combo(opd);
        x1 = (s1 == 2'd1) ? cv : m_b;
        x2 = (s2 == 2'd1) ? m_c : W'(opd);
        case (op)
          2'd0:    res = (cv >= W'(W)) ? '0 : W'(64'(m_a) / (64'd1 << cv[5:0]));
          2'd1:    res = x1 ^ x2;
          default: res = x1 % 8;
        endcase
        if (we[0]) na = res;
        if (we[1]) nb = res;
        if (we[2]) nc = res;
        if (we[3]) begin
          nov = 1; nod = 3'(res % 8); wrote_o = 1;
        end
        if (opd == 3'd7 && (op == 2'd0 || s1 == 2'd1)) nerr = 1;
      end
    end
    if (!wrote_o && m_ov && rdy) nov = 0;
    m_a = na; m_b = nb; m_c = nc; m_ov = nov; m_od = nod;
    m_jr = njr; m_ja = nja; m_err = nerr; m_shadow = nsh;
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic exe(input logic [2:0] opd, input logic [1:0] s1, input logic [1:0] s2,
                     input logic [1:0] op, input logic [4:0] we, input bit rdy);
    cycle(1, opd, s1, s2, op, we, 0, '0, '0, '0, rdy);
  endtask

  task automatic load(input logic [W-1:0] la, input logic [W-1:0] lb, input logic [W-1:0] lc);
    cycle(0, 3'd0, 2'd0, 2'd0, 2'd0, 5'd0, 1, la, lb, lc, 1);
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 3'd0, 2'd0, 2'd0, 2'd0, 5'd0, 0, '0, '0, '0, rdy);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 63));
    return W'({$urandom, $urandom});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; operand_id_reg = '0; op1_sel = '0; op2_sel = '0; operation_sel = '0;
    reg_wr_en = '0; load_en = 0; load_a = '0; load_b = '0; load_c = '0; out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_halt_id", 64'(halt_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADV: A = 2024 >> 1
    load(48'd2024, '0, '0);
    exe(3'd1, COMBO_OP_SEL, LIT_OP_SEL, SHIFT_SEL, REG_A_WR_EN, 1);
    chk("adv_a", 64'(reg_a), 64'd1012);

    // BXL then BXC
    load(48'd1012, 48'd5, 48'd6);
    exe(3'd3, REG_B_SEL, LIT_OP_SEL, XOR_SEL, REG_B_WR_EN, 1);
    chk("bxl_b", 64'(reg_b), 64'd6);
    exe(3'd0, REG_B_SEL, REG_C_SEL, XOR_SEL, REG_B_WR_EN, 1);
    chk("bxc_b", 64'(reg_b), 64'd0);

    // OUT with back-pressure, then a held second OUT
    load(48'h1F, '0, 48'd6);
    exe(3'd4, COMBO_OP_SEL, LIT_OP_SEL, MOD_SEL, REG_O_WR_EN, 0);
    chk("out1_data", 64'(out_data), 64'd7);
    exe(3'd2, COMBO_OP_SEL, LIT_OP_SEL, MOD_SEL, REG_O_WR_EN, 0);
    chk("out_held_data", 64'(out_data), 64'd7);
    exe(3'd2, COMBO_OP_SEL, LIT_OP_SEL, MOD_SEL, REG_O_WR_EN, 1);
    chk("out2_data", 64'(out_data), 64'd2);
    chk("out2_valid", 64'(out_valid), 64'd1);
    idle(1);
    chk("out_drained", 64'(out_valid), 64'd0);

    // JNZ taken: pulse, shadow discards the next instruction
    load(48'd3, '0, '0);
    exe(3'd0, REG_B_SEL, LIT_OP_SEL, JUMP_SEL, REG_A_WR_EN | REG_O_WR_EN, 1);
    chk("jnz_req", 64'(jump_req), 64'd1);
    chk("jnz_addr", 64'(jump_addr), 64'd0);
    exe(3'd1, COMBO_OP_SEL, LIT_OP_SEL, SHIFT_SEL, REG_A_WR_EN, 1);
    chk("shadow_a", 64'(reg_a), 64'd3);
    chk("jnz_pulse_end", 64'(jump_req), 64'd0);
    exe(3'd5, REG_B_SEL, LIT_OP_SEL, JUMP_SEL, NO_WR_EN, 1);
    chk("jnz5_addr", 64'(jump_addr), 64'd5);
    idle(1);
    // JNZ not taken: no pulse, no discard
    load('0, '0, '0);
    exe(3'd0, REG_B_SEL, LIT_OP_SEL, JUMP_SEL, NO_WR_EN, 1);
    chk("jz_req", 64'(jump_req), 64'd0);
    exe(3'd1, REG_B_SEL, LIT_OP_SEL, XOR_SEL, REG_B_WR_EN, 1);
    chk("jz_nodiscard_b", 64'(reg_b), 64'd1);

    // Shift bounds and reserved combo 7
    load(48'd1, '0, 48'd48);
    exe(3'd6, COMBO_OP_SEL, LIT_OP_SEL, SHIFT_SEL, REG_A_WR_EN, 1);
    chk("shift48_a", 64'(reg_a), 64'd0);
    load(48'h8000_0000_0000, '0, 48'd47);
    exe(3'd6, COMBO_OP_SEL, LIT_OP_SEL, SHIFT_SEL, REG_A_WR_EN, 1);
    chk("shift47_a", 64'(reg_a), 64'd1);
    exe(3'd7, COMBO_OP_SEL, LIT_OP_SEL, MOD_SEL, REG_O_WR_EN, 1);
    chk("combo7_data", 64'(out_data), 64'd0);
    chk("combo7_err", 64'(err_combo7), 64'd1);
    repeat (3) idle(1);
    chk("combo7_sticky", 64'(err_combo7), 64'd1);

    // Reset with a pending word, then reset inside a jump shadow
    load(48'd9, 48'd10, 48'd11);
    exe(3'd5, COMBO_OP_SEL, LIT_OP_SEL, MOD_SEL, REG_O_WR_EN, 0);
    pulse_reset("rst_pending");
    load(48'd3, '0, '0);
    exe(3'd1, REG_B_SEL, LIT_OP_SEL, JUMP_SEL, NO_WR_EN, 1);
    pulse_reset("rst_shadow");
    exe(3'd3, REG_B_SEL, LIT_OP_SEL, XOR_SEL, REG_B_WR_EN, 1);
    chk("post_rst_b", 64'(reg_b), 64'd3);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom_range(0, 1)),
            2'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
            $urandom_range(0, 15) == 0, rnd_val(), rnd_val(), rnd_val(),
            $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
